pet_stat_engine: RTL
====================

// Module: pet_stat_engine
// PURPOSE
//  Parametrised N-channel vital-stat engine for the Tamagotchi core. Per-channel saturating
//  counters decay at runtime-programmable tick periods, accept boost pulses from the sensor
//  and button front-ends, and drain the health channel while any need is critical.
//  Adds a registered test mode and a DEAD/revive lifecycle. Feeds the face selector and the 7-seg driver.
// PARAMETERS
//  N_STATS     5         channel count; channels 0..N_STATS-2 are needs, channel N_STATS-1 is health
//  VAL_W       3         bits per stat value
//  VAL_MAX     5         saturation ceiling and reset value (<= 2^VAL_W-1)
//  TICK_DIV    50000000  clk cycles per stat tick (1 s at 50 MHz)
//  PER_W       7         bits per decay-period field
//  CRIT_LVL    2         a need at or below this level is critical
//  WARN_LVL    3         a need at or below this level raises a warning
//  CRIT_PERIOD 10        consecutive critical ticks per health decrement
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous reset, active-high
//  period_i     in   N_STATS*PER_W     decay period in ticks per channel, channel k at [k*PER_W+:PER_W]; 0 = no decay; health field ignored
//  boost_i      in   N_STATS           one-cycle +1 request per channel (feed/sleep/play/.../heal)
//  test_tgl_i   in   1                 one-cycle pulse: toggle ALIVE<->TEST
//  sel_i        in   clog2(N_STATS)    channel selected in TEST
//  inc_i        in   1                 TEST: +1 on selected channel
//  dec_i        in   1                 TEST: -1 on selected channel
//  revive_i     in   1                 DEAD: restart pet
//  values_o     out  N_STATS*VAL_W     registered stat values, channel k at [k*VAL_W+:VAL_W]
//  alarm_o      out  N_STATS           bit k = value k <= CRIT_LVL
//  mood_o       out  2                 0 dead, 1 critical, 2 warning, 3 content
//  test_o       out  1                 high in TEST
//  dead_o       out  1                 high in DEAD
//  tick_o       out  1                 one-cycle stat tick strobe
// BEHAVIOUR
//  Reset: state ALIVE, all values VAL_MAX, prescaler, decay and critical counters 0, tick_o 0, test_o 0, dead_o 0,
//   alarm_o 0, mood_o 3. Reset has priority over every other input and may assert at any cycle.
//  States: ALIVE, TEST, DEAD. ALIVE--test_tgl-->TEST, TEST--test_tgl-->ALIVE,
//   ALIVE/TEST--health==0-->DEAD, DEAD--revive-->ALIVE. test_tgl_i is ignored in DEAD.
//  Prescaler: counts 0..TICK_DIV-1 in ALIVE only and is frozen in TEST/DEAD.
//   tick_o = 1 on the cycle the count equals TICK_DIV-1, then the count wraps to 0.
//  Need decay (ALIVE): on tick, if period_k != 0 the decay counter increments.
//   When it reaches period_k-1 it clears and value_k decrements, floored at 0.
//   A period change takes effect at the next tick. If the counter is >= the new period it clears without a decrement.
//  Health drain (ALIVE): on tick, if any need <= CRIT_LVL the critical counter increments.
//   At CRIT_PERIOD-1 it clears and health decrements. When no need is critical the counter clears on the tick.
//  Boost (ALIVE): boost_i[k] increments value_k, saturating at VAL_MAX. Result is visible the next cycle (1-cycle latency).
//  Simultaneous boost and decay on the same channel in the same cycle: net 0, value unchanged. Same rule for heal vs. health drain.
//  TEST: decay/critical counters hold. boost_i is ignored.
//   inc_i raises value[sel_i] (saturating at VAL_MAX); dec_i lowers it (floored at 0).
//   inc_i and dec_i together: no change. sel_i >= N_STATS: no change.
//  DEAD entry: on the cycle after health reads 0, every value is forced to 0 and all counters clear.
//   boost/inc/dec are ignored in DEAD.
//  revive_i in DEAD: all values go to VAL_MAX, counters go to 0, next state ALIVE. revive_i outside DEAD is ignored.
//  Outputs alarm_o and mood_o are combinational from the registered values and state.
//   mood_o: 0 if DEAD; else 1 if any alarm; else 2 if any value <= WARN_LVL; else 3.
//  All arithmetic is VAL_W wide with explicit saturation; no wrap-around is ever permitted.
// TESTING (sim params TICK_DIV=4, N_STATS=5, CRIT_PERIOD=3)
//  1. rst high 2 cycles -> all values 5, mood_o 3, tick_o pulses every 4th clk after release.
//  2. period_i ch0=2, all others 0 -> ch0 falls 5->4->3 every 2 ticks, floor 0. alarm_o[0]=1 from value 2.
//  3. ch0 at 1, ch0 period 1, boost_i[0] on the decay cycle -> ch0 stays 1. Boost at 5 -> stays 5.
//  4. ch1 held at 0 -> health -1 every 3 ticks. At health 0, next cycle dead_o=1 and all values 0.
//     revive_i -> all 5, ALIVE.
//  5. test_tgl, sel=4, dec x5 -> health 0 -> DEAD. sel=7 + inc -> no change. Prescaler frozen in TEST.
//  6. rst asserted mid-decay with counters nonzero -> next cycle full reset values, tick restarts from 0.

Source files
------------

// File: rtl/pet_stat_engine.sv
// N-channel vital-stat engine: saturating per-channel counters with programmable decay,
// boost pulses, health drain while a need is critical, and an ALIVE/TEST/DEAD lifecycle.
module pet_stat_engine #(
   parameter int N_STATS     = 5,
   parameter int VAL_W       = 3,
   parameter int VAL_MAX     = 5,
   parameter int TICK_DIV    = 50000000,
   parameter int PER_W       = 7,
   parameter int CRIT_LVL    = 2,
   parameter int WARN_LVL    = 3,
   parameter int CRIT_PERIOD = 10,
   localparam int SEL_W      = (N_STATS > 1) ? $clog2(N_STATS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_STATS*PER_W-1:0]   period_i,
   input  logic [N_STATS-1:0]         boost_i,
   input  logic                       test_tgl_i,
   input  logic [SEL_W-1:0]           sel_i,
   input  logic                       inc_i,
   input  logic                       dec_i,
   input  logic                       revive_i,
   output logic [N_STATS*VAL_W-1:0]   values_o,
   output logic [N_STATS-1:0]         alarm_o,
   output logic [1:0]                 mood_o,
   output logic                       test_o,
   output logic                       dead_o,
   output logic                       tick_o
);

   localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CRIT_W = (CRIT_PERIOD > 1) ? $clog2(CRIT_PERIOD) : 1;
   localparam int HEALTH = N_STATS - 1;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      TEST  = 2'd1,
      DEAD  = 2'd2
   } state_t;

   state_t                     state_reg, state_next;
   logic [PRE_W-1:0]           pre_reg, pre_next;
   logic [CRIT_W-1:0]          crit_reg, crit_next;
   logic [N_STATS*VAL_W-1:0]   values_flat;
   logic [N_STATS-1:0]         crit_need;
   logic [N_STATS-1:0]         warn_need;
   logic                       health_zero;
   logic                       kill;
   logic                       revive;
   logic                       run_alive;
   logic                       run_test;
   logic                       tick;
   logic                       drain;
   logic                       any_need_crit;
   logic                       unused_health_period;

   // The health channel has no decay period of its own; it only drains via the critical counter.
   assign unused_health_period = ^period_i[HEALTH*PER_W +: PER_W];

   assign health_zero   = (values_flat[HEALTH*VAL_W +: VAL_W] == '0);
   assign kill          = (state_reg != DEAD) && health_zero;
   assign revive        = (state_reg == DEAD) && revive_i;
   assign run_alive     = (state_reg == ALIVE) && !health_zero;
   assign run_test      = (state_reg == TEST) && !health_zero;
   assign tick          = (state_reg == ALIVE) && (pre_reg == PRE_W'(TICK_DIV - 1));
   assign any_need_crit = |crit_need[N_STATS-2:0];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ALIVE: begin
            if (health_zero)     state_next = DEAD;
            else if (test_tgl_i) state_next = TEST;
         end
         TEST: begin
            if (health_zero)     state_next = DEAD;
            else if (test_tgl_i) state_next = ALIVE;
         end
         DEAD: begin
            if (revive_i)        state_next = ALIVE;
         end
         default:                state_next = ALIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ALIVE;
      else     state_reg <= state_next;
   end

   // Prescaler and critical counter only advance while ALIVE; both restart on death and revival.
   always_comb begin
      pre_next  = pre_reg;
      crit_next = crit_reg;
      drain     = 1'b0;
      if (kill || revive) begin
         pre_next  = '0;
         crit_next = '0;
      end else if (run_alive) begin
         pre_next = tick ? '0 : pre_reg + PRE_W'(1);
         if (tick) begin
            if (!any_need_crit) begin
               crit_next = '0;
            end else if (crit_reg >= CRIT_W'(CRIT_PERIOD - 1)) begin
               crit_next = '0;
               drain     = 1'b1;
            end else begin
               crit_next = crit_reg + CRIT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_reg  <= '0;
         crit_reg <= '0;
      end else begin
         pre_reg  <= pre_next;
         crit_reg <= crit_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_STATS; gi++) begin : g_chan
         logic [VAL_W-1:0] val_reg, val_next;
         logic             decay;
         logic             up;
         logic             down;
         logic             sel_hit;

         assign sel_hit = (sel_i == SEL_W'(gi));

         if (gi < HEALTH) begin : g_need
            logic [PER_W-1:0] dcnt_reg, dcnt_next;
            logic [PER_W-1:0] period;

            assign period = period_i[gi*PER_W +: PER_W];

            // A counter already past a freshly shortened period restarts without a decrement.
            always_comb begin
               dcnt_next = dcnt_reg;
               decay     = 1'b0;
               if (kill || revive) begin
                  dcnt_next = '0;
               end else if (run_alive && tick) begin
                  if (dcnt_reg >= period) begin
                     dcnt_next = '0;
                  end else if ((dcnt_reg + PER_W'(1)) == period) begin
                     dcnt_next = '0;
                     decay     = 1'b1;
                  end else begin
                     dcnt_next = dcnt_reg + PER_W'(1);
                  end
               end
            end

            always_ff @(posedge clk) begin
               if (rst) dcnt_reg <= '0;
               else     dcnt_reg <= dcnt_next;
            end
         end else begin : g_health
            assign decay = drain;
         end

         // Opposing +1/-1 requests in the same cycle cancel before saturation is applied.
         always_comb begin
            up   = 1'b0;
            down = 1'b0;
            if (run_alive) begin
               up   = boost_i[gi];
               down = decay;
            end else if (run_test && sel_hit && (inc_i != dec_i)) begin
               up   = inc_i;
               down = dec_i;
            end
            val_next = val_reg;
            if (kill) begin
               val_next = '0;
            end else if (revive) begin
               val_next = VAL_W'(VAL_MAX);
            end else if (up && !down && (val_reg < VAL_W'(VAL_MAX))) begin
               val_next = val_reg + VAL_W'(1);
            end else if (down && !up && (val_reg != '0)) begin
               val_next = val_reg - VAL_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) val_reg <= VAL_W'(VAL_MAX);
            else     val_reg <= val_next;
         end

         assign values_flat[gi*VAL_W +: VAL_W] = val_reg;
         assign crit_need[gi] = (val_reg <= VAL_W'(CRIT_LVL));
         assign warn_need[gi] = (val_reg <= VAL_W'(WARN_LVL));
      end
   endgenerate

   always_comb begin
      if (state_reg == DEAD) mood_o = 2'd0;
      else if (|crit_need)   mood_o = 2'd1;
      else if (|warn_need)   mood_o = 2'd2;
      else                   mood_o = 2'd3;
   end

   assign values_o = values_flat;
   assign alarm_o  = crit_need;
   assign test_o   = (state_reg == TEST);
   assign dead_o   = (state_reg == DEAD);
   assign tick_o   = tick;

endmodule
